incr_pulse_driver: RTL and testbench
====================================

Name: incr_pulse_driver

Overview:
- Transmit-side counterpart of the counter/delay test target. It generates the increment pulse train and the trailing secondary strobe that the target samples.
- On a start request it emits a programmed number of single-cycle increment pulses with a programmed idle gap between them. It then optionally strobes the secondary line and reports done.
- It keeps a local mirror of the target's 4-bit wrap-around count, so benches can compare directly against the target's count output.

Parameters:
- COUNT_W, 4, width of the pulse-count request and of the mirrored count. This matches the target's 4-bit counter.
- GAP_W, 4, width of the inter-pulse gap request, in idle cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk.
- start_in  input  1  request a burst; sampled only when busy_out=0.
- count_in  input  COUNT_W  number of increment pulses in the burst (0..2^COUNT_W-1).
- gap_in  input  GAP_W  idle cycles inserted between consecutive pulses.
- mark_in  input  1  when 1, assert secondary_out once at burst end.
- clear_in  input  1  synchronous clear of sent_out.
- incr_out  output  1  increment pulse to the target (drives its incr input).
- secondary_out  output  1  end-of-burst strobe (drives the target's secondary input).
- busy_out  output  1  burst in progress.
- done_out  output  1  one-cycle burst-complete pulse.
- sent_out  output  COUNT_W  mirrored count: total pulses issued, modulo 2^COUNT_W.
- slow_out  output  1  equals sent_out[COUNT_W-1], mirroring the target's slow output.

Behaviour:
- All outputs are registered except slow_out, which is a combinational tap of sent_out.
- Reset (rst=0, asynchronous) forces:
  - state to IDLE and internal counters to 0;
  - incr_out, secondary_out, busy_out and done_out to 0;
  - sent_out to 0.
- Reset mid-burst aborts the burst immediately. done_out is not pulsed for an aborted burst.
- State machine: IDLE, PULSE, GAP, FINISH.
- IDLE (busy_out=0):
  - start_in=1 with count_in≠0: latch count_in, gap_in and mark_in, then go to PULSE.
  - start_in=1 with count_in=0: go to FINISH directly. No incr pulses are issued; the mark strobe still applies.
- PULSE (busy_out=1):
  - incr_out=1 for exactly this one cycle.
  - remaining is decremented; sent_out increments and wraps from 2^COUNT_W-1 to 0.
  - Next state: remaining reaches 0 → FINISH; otherwise latched gap=0 → PULSE (back-to-back pulses); otherwise → GAP with timer=gap.
- GAP (busy_out=1):
  - incr_out=0; timer is decremented each cycle.
  - Leaves to PULSE after exactly gap cycles, so the pulse period is gap+1 cycles.
- FINISH (busy_out=1):
  - secondary_out = latched mark for this one cycle; done_out=1 for this one cycle.
  - Next state: IDLE. busy_out is 0 in the cycle after FINISH.
- Latency: start accepted at edge k → first incr_out high in the cycle following edge k.
- Burst length in cycles = count + (count-1)*gap + 1 (the final 1 is FINISH). The zero-count burst takes 1 cycle.
- start_in while busy_out=1 is ignored; it is not queued. count_in, gap_in and mark_in are don't-care outside acceptance.
- A new start_in in the same cycle FINISH is active is ignored. The earliest acceptance is the first IDLE cycle.
- clear_in=1 sets sent_out to 0 at the next edge. If a PULSE is active in the same cycle, clear wins: sent_out=0, and incr_out is still emitted.
- sent_out persists across bursts; only reset and clear_in zero it.

Test Plan:
- Reset: hold rst=0 with start_in=1 → all outputs 0, busy_out=0. Release rst → still IDLE, no pulses.
- Basic burst: count_in=3, gap_in=2, mark_in=1 → incr_out high on cycles 1, 4 and 7 after acceptance. secondary_out and done_out high on cycle 8, sent_out=3, busy_out=0 on cycle 9.
- Back-to-back wrap: sent_out=14 first, then count_in=3, gap_in=0 → three consecutive incr_out cycles, sent_out steps 15, 0, 1, and slow_out goes 1→0.
- Zero count: count_in=0, mark_in=1 → no incr_out, secondary_out=done_out=1 one cycle after acceptance, sent_out unchanged.
- Busy rejection and clear: start a count=5 burst, pulse start_in mid-burst with count_in=9 → exactly 5 pulses. clear_in coinciding with a pulse → sent_out=0 that edge.
- Async abort: assert rst=0 during GAP of a count=4 burst → outputs drop immediately, no done_out. A new burst after release behaves normally.
- Loopback: drive the target's incr and secondary inputs from this block → the target's count output equals sent_out. The target's delayed-increment output follows incr_out by 1 cycle, and its delayed-secondary output follows secondary_out by 1 cycle.

Source files
------------

// File: rtl/incr_pulse_driver.sv
// Increment pulse-train generator for the counter/delay target: issues a programmed
// number of spaced incr pulses, an optional end strobe, and mirrors the target's count.
module incr_pulse_driver #(
    parameter int COUNT_W = 4,
    parameter int GAP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_in,
    input  logic [COUNT_W-1:0] count_in,
    input  logic [GAP_W-1:0]   gap_in,
    input  logic               mark_in,
    input  logic               clear_in,
    output logic               incr_out,
    output logic               secondary_out,
    output logic               busy_out,
    output logic               done_out,
    output logic [COUNT_W-1:0] sent_out,
    output logic               slow_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
    localparam logic [GAP_W-1:0]   GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0]   GAP_ONE  = GAP_W'(1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [COUNT_W-1:0] remaining_r;
    logic [COUNT_W-1:0] remaining_nxt_s;
    logic [GAP_W-1:0]   gap_r;
    logic [GAP_W-1:0]   gap_nxt_s;
    logic [GAP_W-1:0]   timer_r;
    logic [GAP_W-1:0]   timer_nxt_s;
    logic               mark_r;
    logic               mark_nxt_s;
    logic [COUNT_W-1:0] sent_r;
    logic [COUNT_W-1:0] sent_nxt_s;
    logic               incr_r;
    logic               secondary_r;
    logic               busy_r;
    logic               done_r;

    // Next-state, burst parameter latching and count bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        gap_nxt_s       = gap_r;
        timer_nxt_s     = timer_r;
        mark_nxt_s      = mark_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    remaining_nxt_s = count_in;
                    gap_nxt_s       = gap_in;
                    mark_nxt_s      = mark_in;
                    if (count_in != CNT_ZERO) begin
                        state_nxt_s = ST_PULSE;
                    end else begin
                        state_nxt_s = ST_FINISH;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                remaining_nxt_s = remaining_r - CNT_ONE;
                if (remaining_r == CNT_ONE) begin
                    state_nxt_s = ST_FINISH;
                end else if (gap_r == GAP_ZERO) begin
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_GAP;
                    timer_nxt_s = gap_r;
                end
            end
            ST_GAP: begin
                // Timer holds the idle cycles still owed, including this one.
                if (timer_r <= GAP_ONE) begin
                    state_nxt_s = ST_PULSE;
                    timer_nxt_s = GAP_ZERO;
                end else begin
                    state_nxt_s = ST_GAP;
                    timer_nxt_s = timer_r - GAP_ONE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Mirror of the target count: the target counts on the edge closing each pulse cycle.
    always_comb begin
        sent_nxt_s = sent_r;
        if (clear_in) begin
            sent_nxt_s = CNT_ZERO;
        end else if (state_r == ST_PULSE) begin
            sent_nxt_s = sent_r + CNT_ONE;
        end else begin
            sent_nxt_s = sent_r;
        end
    end

    // State, burst registers and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= CNT_ZERO;
            gap_r       <= GAP_ZERO;
            timer_r     <= GAP_ZERO;
            mark_r      <= 1'b0;
            sent_r      <= CNT_ZERO;
            incr_r      <= 1'b0;
            secondary_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            gap_r       <= gap_nxt_s;
            timer_r     <= timer_nxt_s;
            mark_r      <= mark_nxt_s;
            sent_r      <= sent_nxt_s;
            incr_r      <= (state_nxt_s == ST_PULSE);
            secondary_r <= (state_nxt_s == ST_FINISH) && mark_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_FINISH);
        end
    end

    assign incr_out      = incr_r;
    assign secondary_out = secondary_r;
    assign busy_out      = busy_r;
    assign done_out      = done_r;
    assign sent_out      = sent_r;
    assign slow_out      = sent_r[COUNT_W-1];

endmodule

// File: tb/tb_incr_pulse_driver.sv
// Directed self-checking bench for incr_pulse_driver, with a small behavioural
// model of the counter/delay target wired in loopback.
module tb_incr_pulse_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic [3:0] count_in;
    logic [3:0] gap_in;
    logic       mark_in;
    logic       clear_in;
    logic       incr_out;
    logic       secondary_out;
    logic       busy_out;
    logic       done_out;
    logic [3:0] sent_out;
    logic       slow_out;

    logic [3:0] tgt_cnt;
    logic       tgt_incr_d;
    logic       tgt_sec_d;

    int total = 0;
    int bad   = 0;
    int npulse;

    incr_pulse_driver #(.COUNT_W(4), .GAP_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .count_in      (count_in),
        .gap_in        (gap_in),
        .mark_in       (mark_in),
        .clear_in      (clear_in),
        .incr_out      (incr_out),
        .secondary_out (secondary_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .sent_out      (sent_out),
        .slow_out      (slow_out)
    );

    always #5 clk = ~clk;

    // Behavioural target: 4-bit wrap counter plus one-cycle delayed incr/secondary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_cnt    <= 4'd0;
            tgt_incr_d <= 1'b0;
            tgt_sec_d  <= 1'b0;
        end else begin
            if (incr_out) tgt_cnt <= tgt_cnt + 4'd1;
            tgt_incr_d <= incr_out;
            tgt_sec_d  <= secondary_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; start_in = 1'b1; count_in = 4'd5; gap_in = 4'd1; mark_in = 1'b1; clear_in = 1'b0;

        // Reset held with start asserted
        repeat (3) step();
        chk("rst_incr", 32'(incr_out), 32'd0);
        chk("rst_sec", 32'(secondary_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_sent", 32'(sent_out), 32'd0);
        chk("rst_slow", 32'(slow_out), 32'd0);
        start_in = 1'b0;
        rst = 1'b1;
        step(); step();
        chk("rel_busy", 32'(busy_out), 32'd0);
        chk("rel_incr", 32'(incr_out), 32'd0);

        // Basic burst: count 3, gap 2, mark 1
        count_in = 4'd3; gap_in = 4'd2; mark_in = 1'b1; start_in = 1'b1;
        step();
        start_in = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("basic_incr_c%0d", c), 32'(incr_out), 32'((c == 1) || (c == 4) || (c == 7)));
            chk($sformatf("basic_done_c%0d", c), 32'(done_out), 32'(c == 8));
            chk($sformatf("basic_sec_c%0d", c), 32'(secondary_out), 32'(c == 8));
            chk($sformatf("basic_busy_c%0d", c), 32'(busy_out), 32'(c <= 8));
            if (c < 9) step();
        end
        chk("basic_sent", 32'(sent_out), 32'd3);
        chk("basic_loop_cnt", 32'(tgt_cnt), 32'd3);

        // Bring sent_out to 14 with an 11-pulse back-to-back burst
        count_in = 4'd11; gap_in = 4'd0; mark_in = 1'b0; start_in = 1'b1;
        step();
        start_in = 1'b0;
        repeat (12) step();
        chk("pre_wrap_busy", 32'(busy_out), 32'd0);
        chk("pre_wrap_sent", 32'(sent_out), 32'd14);

        // Back-to-back wrap: 3 pulses, gap 0
        count_in = 4'd3; gap_in = 4'd0; start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("wrap_c1_incr", 32'(incr_out), 32'd1);
        chk("wrap_c1_sent", 32'(sent_out), 32'd14);
        step();
        chk("wrap_c2_incr", 32'(incr_out), 32'd1);
        chk("wrap_c2_sent", 32'(sent_out), 32'd15);
        chk("wrap_c2_slow", 32'(slow_out), 32'd1);
        step();
        chk("wrap_c3_incr", 32'(incr_out), 32'd1);
        chk("wrap_c3_sent", 32'(sent_out), 32'd0);
        chk("wrap_c3_slow", 32'(slow_out), 32'd0);
        step();
        chk("wrap_c4_incr", 32'(incr_out), 32'd0);
        chk("wrap_c4_done", 32'(done_out), 32'd1);
        chk("wrap_c4_sec", 32'(secondary_out), 32'd0);
        chk("wrap_c4_sent", 32'(sent_out), 32'd1);
        step();
        chk("wrap_c5_busy", 32'(busy_out), 32'd0);
        chk("wrap_loop_cnt", 32'(tgt_cnt), 32'd1);

        // Zero-count burst with mark
        count_in = 4'd0; gap_in = 4'd3; mark_in = 1'b1; start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("zero_incr", 32'(incr_out), 32'd0);
        chk("zero_sec", 32'(secondary_out), 32'd1);
        chk("zero_done", 32'(done_out), 32'd1);
        chk("zero_busy", 32'(busy_out), 32'd1);
        step();
        chk("zero_after_busy", 32'(busy_out), 32'd0);
        chk("zero_after_done", 32'(done_out), 32'd0);
        chk("zero_sent", 32'(sent_out), 32'd1);

        // Busy rejection: count 5, gap 1, second start mid-burst with count 9
        count_in = 4'd5; gap_in = 4'd1; mark_in = 1'b0; start_in = 1'b1;
        step();
        start_in = 1'b0;
        npulse = 0;
        for (int c = 1; c <= 12; c++) begin
            if (incr_out) npulse++;
            if (c == 3) begin
                start_in = 1'b1; count_in = 4'd9;
            end else begin
                start_in = 1'b0;
            end
            step();
        end
        chk("busy_rej_pulses", 32'(npulse), 32'd5);
        chk("busy_rej_busy", 32'(busy_out), 32'd0);
        chk("busy_rej_sent", 32'(sent_out), 32'd6);

        // Clear coinciding with a pulse
        count_in = 4'd2; gap_in = 4'd0; mark_in = 1'b0; start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("clr_c1_sent", 32'(sent_out), 32'd6);
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        chk("clr_c2_incr", 32'(incr_out), 32'd1);
        chk("clr_c2_sent", 32'(sent_out), 32'd0);
        step();
        chk("clr_c3_sent", 32'(sent_out), 32'd1);
        chk("clr_c3_done", 32'(done_out), 32'd1);

        // Async abort during GAP of a count-4 burst
        step();
        count_in = 4'd4; gap_in = 4'd3; mark_in = 1'b1; start_in = 1'b1;
        step();
        start_in = 1'b0;
        step();
        chk("abort_pre_busy", 32'(busy_out), 32'd1);
        chk("abort_pre_incr", 32'(incr_out), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_sent", 32'(sent_out), 32'd0);
        chk("abort_done", 32'(done_out), 32'd0);
        step(); step();
        chk("abort_hold_done", 32'(done_out), 32'd0);
        rst = 1'b1;
        step();
        chk("abort_rel_busy", 32'(busy_out), 32'd0);

        // Fresh burst after abort, with loopback checks
        count_in = 4'd2; gap_in = 4'd1; mark_in = 1'b1; start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk("post_c1_incr", 32'(incr_out), 32'd1);
        step();
        chk("post_c2_incr", 32'(incr_out), 32'd0);
        chk("loop_incr_d", 32'(tgt_incr_d), 32'd1);
        step();
        chk("post_c3_incr", 32'(incr_out), 32'd1);
        step();
        chk("post_c4_done", 32'(done_out), 32'd1);
        chk("post_c4_sec", 32'(secondary_out), 32'd1);
        step();
        chk("post_c5_busy", 32'(busy_out), 32'd0);
        chk("post_c5_sent", 32'(sent_out), 32'd2);
        chk("loop_sec_d", 32'(tgt_sec_d), 32'd1);
        chk("loop_cnt", 32'(tgt_cnt), 32'(sent_out));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
